// File: rtl/data_memory_hs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_hs_pkg
// Description : Shared definitions for the handshaked data memory: RV32I
//               funct3 width encodings, FSM state type and access helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package data_memory_hs_pkg;

  // RV32I load/store funct3 width encodings
  localparam logic [2:0] MEM_BYTE   = 3'b000;
  localparam logic [2:0] MEM_HALF   = 3'b001;
  localparam logic [2:0] MEM_WORD   = 3'b010;
  localparam logic [2:0] MEM_BYTE_U = 3'b100;
  localparam logic [2:0] MEM_HALF_U = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  function automatic logic width_legal(input logic [2:0] width);
    case (width)
      MEM_BYTE, MEM_HALF, MEM_WORD, MEM_BYTE_U, MEM_HALF_U: width_legal = 1'b1;
      default:                                              width_legal = 1'b0;
    endcase
  endfunction

  // Lane byte enables for a naturally aligned access at byte offset off
  function automatic logic [3:0] byte_enables(input logic [2:0] width,
                                              input logic [1:0] off);
    case (width[1:0])
      2'b00:   byte_enables = 4'b0001 << off;
      2'b01:   byte_enables = 4'b0011 << off;
      default: byte_enables = 4'b1111;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory_hs_bank.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bank
// Description : One byte lane of the data memory. Byte-wide RAM with a write
//               enable and a registered synchronous read port. Contents are
//               not reset.
// Ports       : clk   - clock
//               we    - write enable (wdata stored at addr)
//               re    - read enable (rdata updated with mem[addr])
//               addr  - word index
//               wdata - byte to store
//               rdata - registered read byte, held until the next read
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bank #(
  parameter int ENTRIES = 1024,
  parameter int AW      = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] r_mem [ENTRIES];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    if (re) begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/data_memory_hs.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_hs
// Description : Handshaked RV32I data memory. One request at a time over a
//               valid/ready interface; four byte-lane banks; sign/zero
//               extended load data after LATENCY cycles; misaligned,
//               out-of-range and illegal-width accesses answer with resp_err.
// Ports       : clk, rst_n (async, active-low)
//               req_valid/req_ready, req_addr, req_we, req_width, req_wdata
//               resp_valid/resp_ready, resp_rdata, resp_err
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_hs
  import data_memory_hs_pkg::*;
#(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [2:0]  req_width,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         ADDR_BITS  = $clog2(DEPTH);
  localparam int         WORD_BITS  = ADDR_BITS - 2;
  localparam logic [2:0] C_CNT_LOAD = 3'(LATENCY - 1);

  dmem_state_e r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;

  // Fields latched at acceptance for building the response
  logic [1:0]  r_off;
  logic [2:0]  r_width;
  logic        r_we;
  logic        r_err;

  logic        w_accept;
  logic        w_err;
  logic        w_go;
  logic [3:0]  w_be;
  logic [31:0] w_wlanes;
  logic [31:0] w_raw;
  logic [31:0] w_shifted;
  logic [31:0] w_ext;

  assign req_ready = (r_state == IDLE);
  assign w_accept  = req_valid & req_ready;

  // Error check; width[1:0]==01 covers both H and HU once the width is legal
  always_comb begin
    w_err = 1'b0;
    if (req_addr >= 32'(DEPTH))                                w_err = 1'b1;
    if (!width_legal(req_width))                               w_err = 1'b1;
    if ((req_width[1:0] == 2'b01) && req_addr[0])              w_err = 1'b1;
    if ((req_width == MEM_WORD) && (req_addr[1:0] != 2'b00))   w_err = 1'b1;
  end

  // An accepted, error-free request touches the banks on its acceptance edge
  assign w_go = w_accept & ~w_err;
  assign w_be = byte_enables(req_width, req_addr[1:0]);

  // Replicate store data so every enabled lane sees its little-endian byte
  always_comb begin
    case (req_width[1:0])
      2'b00:   w_wlanes = {4{req_wdata[7:0]}};
      2'b01:   w_wlanes = {2{req_wdata[15:0]}};
      default: w_wlanes = req_wdata;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    dmem_bank #(
      .ENTRIES (DEPTH / 4),
      .AW      (WORD_BITS)
    ) u_bank (
      .clk   (clk),
      .we    (w_go & req_we & w_be[i]),
      .re    (w_go & ~req_we),
      .addr  (req_addr[ADDR_BITS-1:2]),
      .wdata (w_wlanes[8*i +: 8]),
      .rdata (w_raw[8*i +: 8])
    );
  end

  // FSM state register and latched response fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_off   <= 2'd0;
      r_width <= 3'd0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_off   <= req_addr[1:0];
        r_width <= req_width;
        r_we    <= req_we;
        r_err   <= w_err;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_cnt_nxt   = C_CNT_LOAD;
          w_state_nxt = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        // Counter value 1 marks the last waiting cycle
        w_cnt_nxt = r_cnt - 3'd1;
        if (r_cnt <= 3'd1) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Response: lane select by offset, then extend per width
  assign w_shifted = w_raw >> {r_off, 3'b000};

  always_comb begin
    case (r_width)
      MEM_BYTE:   w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
      MEM_BYTE_U: w_ext = {24'd0, w_shifted[7:0]};
      MEM_HALF:   w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      MEM_HALF_U: w_ext = {16'd0, w_shifted[15:0]};
      MEM_WORD:   w_ext = w_shifted;
      default:    w_ext = 32'd0;
    endcase
  end

  assign resp_valid = (r_state == RESP);
  assign resp_err   = resp_valid & r_err;
  assign resp_rdata = (resp_valid && !r_we && !r_err) ? w_ext : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_hs
// Description : Directed self-checking bench for data_memory_hs. Two
//               instances share request fields: LATENCY=1 and LATENCY=3,
//               selected per transaction by sel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_hs;
  import data_memory_hs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] req_addr, req_wdata;
  logic        req_we;
  logic [2:0]  req_width;
  logic        resp_ready;
  logic        req_valid1, req_valid3;
  logic        req_ready1, req_ready3;
  logic        resp_valid1, resp_valid3;
  logic [31:0] resp_rdata1, resp_rdata3;
  logic        resp_err1, resp_err3;
  logic        sel;

  logic        m_req_ready, m_resp_valid, m_resp_err;
  logic [31:0] m_resp_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  data_memory_hs #(.DEPTH(4096), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_addr(req_addr), .req_we(req_we), .req_width(req_width),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid1), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  data_memory_hs #(.DEPTH(4096), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_addr(req_addr), .req_we(req_we), .req_width(req_width),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid3), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata3), .resp_err(resp_err3)
  );

  assign m_req_ready  = sel ? req_ready3  : req_ready1;
  assign m_resp_valid = sel ? resp_valid3 : resp_valid1;
  assign m_resp_rdata = sel ? resp_rdata3 : resp_rdata1;
  assign m_resp_err   = sel ? resp_err3   : resp_err1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Present a request for one edge, then wait (bounded) for resp_valid.
  // Entered and left at posedge+1.
  task automatic issue(input logic s, input logic we, input logic [2:0] w,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic e, output int lat);
    sel = s; req_we = we; req_width = w; req_addr = a; req_wdata = d;
    if (s) req_valid3 = 1'b1; else req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0; req_valid3 = 1'b0;
    lat = 1;
    while (!m_resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = m_resp_rdata;
    e  = m_resp_err;
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic xfer(input string tag, input logic s, input logic we,
                      input logic [2:0] w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_e, input int exp_lat);
    logic [31:0] rd;
    logic        e;
    int          lat;
    issue(s, we, w, a, d, rd, e, lat);
    check({tag, "_lat"},   32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"},   {31'd0, e}, {31'd0, exp_e});
    handshake();
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    logic        rdy_seen;

    req_valid1 = 1'b0; req_valid3 = 1'b0; resp_ready = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; req_we = 1'b0; req_width = MEM_WORD;
    sel = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready",  {31'd0, req_ready1},  32'd1);
    check("rst_resp_valid", {31'd0, resp_valid1}, 32'd0);
    check("rst_resp_rdata", resp_rdata1,          32'd0);
    check("rst_resp_err",   {31'd0, resp_err1},   32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LATENCY=1 basic store/load and sub-word extension
    xfer("sw_100",  0, 1, MEM_WORD,   32'h100, 32'hDEADBEEF, 32'h0,        0, 1);
    xfer("lw_100",  0, 0, MEM_WORD,   32'h100, 32'h0,        32'hDEADBEEF, 0, 1);
    xfer("lb_103",  0, 0, MEM_BYTE,   32'h103, 32'h0,        32'hFFFFFFDE, 0, 1);
    xfer("lbu_103", 0, 0, MEM_BYTE_U, 32'h103, 32'h0,        32'h000000DE, 0, 1);
    xfer("lh_102",  0, 0, MEM_HALF,   32'h102, 32'h0,        32'hFFFFDEAD, 0, 1);
    xfer("lhu_100", 0, 0, MEM_HALF_U, 32'h100, 32'h0,        32'h0000BEEF, 0, 1);

    // Error responses
    xfer("sh_101_err",  0, 1, MEM_HALF, 32'h101,  32'h1234, 32'h0,        1, 1);
    xfer("lw_100_post", 0, 0, MEM_WORD, 32'h100,  32'h0,    32'hDEADBEEF, 0, 1);
    xfer("lw_1000_err", 0, 0, MEM_WORD, 32'h1000, 32'h0,    32'h0,        1, 1);
    xfer("w011_err",    0, 0, 3'b011,   32'h100,  32'h0,    32'h0,        1, 1);
    xfer("lw_102_err",  0, 0, MEM_WORD, 32'h102,  32'h0,    32'h0,        1, 1);

    // Byte store into an existing word
    xfer("sw_200", 0, 1, MEM_WORD, 32'h200, 32'h11223344, 32'h0,        0, 1);
    xfer("sb_201", 0, 1, MEM_BYTE, 32'h201, 32'h00000055, 32'h0,        0, 1);
    xfer("lw_200", 0, 0, MEM_WORD, 32'h200, 32'h0,        32'h11225544, 0, 1);

    // resp_ready already high when RESP is entered: handshake on first edge
    sel = 1'b0; req_we = 1'b0; req_width = MEM_WORD; req_addr = 32'h200;
    resp_ready = 1'b1; req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    check("early_rdy_valid", {31'd0, resp_valid1}, 32'd1);
    check("early_rdy_rdata", resp_rdata1, 32'h11225544);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("early_rdy_done",  {31'd0, resp_valid1}, 32'd0);
    check("early_rdy_ready", {31'd0, req_ready1},  32'd1);

    // LATENCY=3 with back-pressure
    xfer("l3_sw_40", 1, 1, MEM_WORD, 32'h40, 32'hCAFEF00D, 32'h0, 0, 3);
    sel = 1'b1; req_we = 1'b0; req_width = MEM_WORD; req_addr = 32'h40;
    req_valid3 = 1'b1;
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    lat = 1;
    rdy_seen = 1'b0;
    while (!resp_valid3 && lat < 20) begin
      if (req_ready3) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check("l3_lat",            32'(lat), 32'd3);
    check("l3_ready_low_wait", {31'd0, rdy_seen}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("l3_hold_valid", {31'd0, resp_valid3}, 32'd1);
      check("l3_hold_rdata", resp_rdata3, 32'hCAFEF00D);
      check("l3_hold_ready", {31'd0, req_ready3}, 32'd0);
      @(posedge clk); #1;
    end
    handshake();
    check("l3_post_ready", {31'd0, req_ready3},  32'd1);
    check("l3_post_valid", {31'd0, resp_valid3}, 32'd0);

    // Reset while a store response is pending in WAIT
    sel = 1'b1; req_we = 1'b1; req_width = MEM_WORD; req_addr = 32'h84;
    req_wdata = 32'h12345678; req_valid3 = 1'b1;
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    @(posedge clk); #1;
    check("rstw_in_wait", {31'd0, req_ready3}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rstw_valid", {31'd0, resp_valid3}, 32'd0);
    check("rstw_ready", {31'd0, req_ready3},  32'd1);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstw_next_valid", {31'd0, resp_valid3}, 32'd0);
    check("rstw_next_ready", {31'd0, req_ready3},  32'd1);
    xfer("rstw_lw_84", 1, 0, MEM_WORD, 32'h84, 32'h0, 32'h12345678, 0, 3);
    xfer("rstw_lhu_86", 1, 0, MEM_HALF_U, 32'h86, 32'h0, 32'h00001234, 0, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_memory_hs.md
# data_memory_hs

Handshaked, parametrised data memory for the RV32I load/store path. It accepts one request at a time over a valid/ready interface and stores bytes in four byte-lane banks with synchronous read. It returns sign- or zero-extended load data after a configurable latency. Misaligned, out-of-range and illegal-width accesses produce an error response instead of a silent access, which lets the core take a load/store fault.

## Interface
- DEPTH, 4096, size in bytes; power of two, ≥16.
- LATENCY, 1, cycles from request acceptance to first `resp_valid`; legal range 1..4.
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_addr  input  32  byte address.
- req_we  input  1  1 = store, 0 = load.
- req_width  input  3  access width; RV32I funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  access faulted.

## Operation
- FSM has three states: IDLE, WAIT, RESP.
- `req_ready` = (state == IDLE), driven combinationally.
- A request is accepted when `req_valid && req_ready` at a rising edge. At that edge:
  - The request is checked for errors.
  - Fields needed for the response are latched: `addr[1:0]`, width, we, err.
  - The latency counter is loaded with LATENCY−1.
- Error conditions (any one sets `err`):
  - `req_addr >= DEPTH`.
  - Width 011, 110 or 111.
  - Halfword with `addr[0]=1`.
  - Word with `addr[1:0]≠0`.
- An error request writes nothing and reads nothing.
- Valid store:
  - Byte enables come from width and `addr[1:0]`, with data steered to the lanes, little-endian.
  - The bank write is committed at the acceptance edge.
- Valid load: all four lanes at word index `addr[ADDR_BITS-1:2]` are read synchronously at the acceptance edge into a raw word register.
- State transitions:
  - IDLE → WAIT on acceptance if LATENCY>1; IDLE → RESP if LATENCY==1.
  - WAIT decrements the counter and goes to RESP when the counter reaches 1.
  - RESP → IDLE on `resp_valid && resp_ready`.
- Response path (combinational from latched fields): lane select by `addr[1:0]`, then sign- or zero-extend per width.
- `resp_rdata` and `resp_err` are stable for as long as `resp_valid` is held.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, counter 0.
- `resp_valid` rises exactly LATENCY cycles after the acceptance edge.
- `resp_valid` holds until `resp_ready` is sampled high; back-pressure is unbounded.
- After the response handshake, `req_ready` is 1 in the next cycle. Minimum spacing between acceptances is therefore LATENCY+1 cycles.
- Requests presented while `req_ready`=0 are ignored; the requester holds them.
- Read-after-write: a load accepted after a store's acceptance edge sees the stored data.
- Reset asserted mid-operation:
  - The FSM returns to IDLE immediately and any pending response is dropped.
  - A store already accepted remains written.
- Simultaneous `resp_ready` with RESP entry: the handshake completes on the first edge where `resp_valid` and `resp_ready` are both 1.

## Structure
- Shared package gets:
  - Width encodings MEM_BYTE=3'b000, MEM_HALF=3'b001, MEM_WORD=3'b010, MEM_BYTE_U=3'b100, MEM_HALF_U=3'b101.
  - Typedef `dmem_state_e` {IDLE, WAIT, RESP}.
- Sub-module `dmem_bank`: a byte-wide RAM, DEPTH/4 entries, with write enable and registered synchronous read. It is instantiated once per byte lane (4 instances).
- The top level holds the FSM, counter, error check, lane steering and extension.

## Test plan
- LATENCY=1: SW 0xDEADBEEF @0x100, then LW @0x100 → `resp_rdata`=0xDEADBEEF, `resp_err`=0, `resp_valid` one cycle after acceptance.
- Same data loaded with sub-word accesses:
  - LB @0x103 → 0xFFFFFFDE.
  - LBU @0x103 → 0x000000DE.
  - LH @0x102 → 0xFFFFDEAD.
  - LHU @0x100 → 0x0000BEEF.
- Errors with DEPTH=4096:
  - SH @0x101 → `resp_err`=1, `rdata`=0; a following LW @0x100 still returns 0xDEADBEEF.
  - LW @0x1000 → `resp_err`=1.
  - Width 011 → `resp_err`=1.
- LATENCY=3 with `resp_ready` held low for 5 cycles:
  - `resp_valid` rises 3 cycles after acceptance and stays asserted with stable data.
  - `req_ready`=0 throughout; `req_ready`=1 in the cycle after the handshake.
- SB 0x55 @0x201 → a later LW @0x200 shows 0x55 in bits [15:8]; the other bytes keep their prior values.
- Reset in WAIT state → `resp_valid`=0, `req_ready`=1 in the next cycle; the store accepted before reset is still readable.
